// File: rtl/vcve2_pkg.sv
// Shared vector-sequencer definitions: SEW codes, FSM state enum and SEW decode helpers.
package vcve2_pkg;

    localparam logic [2:0] VSEW_8  = 3'b000;
    localparam logic [2:0] VSEW_16 = 3'b001;
    localparam logic [2:0] VSEW_32 = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } vec_seq_state_e;

    // log2 of the element size in bytes; illegal codes decode to 0 and are rejected separately.
    function automatic logic [1:0] sew_shift(input logic [2:0] vsew);
        case (vsew)
            VSEW_16: sew_shift = 2'd1;
            VSEW_32: sew_shift = 2'd2;
            default: sew_shift = 2'd0;
        endcase
    endfunction

    function automatic logic sew_legal(input logic [2:0] vsew);
        sew_legal = (vsew == VSEW_8) || (vsew == VSEW_16) || (vsew == VSEW_32);
    endfunction

endpackage

// File: rtl/vcve2_vec_tail_mask.sv
// Write-back byte enables for one 32-bit word: tail trim on the last word, head trim on the first.
module vcve2_vec_tail_mask (
    input  logic [1:0] rem_i,
    input  logic [1:0] voff_i,
    input  logic       first_i,
    input  logic       last_i,
    output logic [3:0] be_o
);

    always_comb begin
        be_o = 4'b1111;
        if (last_i && (rem_i != 2'd0)) begin
            be_o = be_o & ((4'b0001 << rem_i) - 4'b0001);
        end
        if (first_i) begin
            be_o = be_o & ~((4'b0001 << voff_i) - 4'b0001);
        end
    end

endmodule

// File: rtl/vcve2_vec_sequencer.sv
// Vector instruction sequencer: walks the register file one 32-bit word at a time.
// Optional resume-from-vstart support is compiled in with VCVE2_VSTART_EN.
module vcve2_vec_sequencer
    import vcve2_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         ready_o,
    input  logic [$clog2(VLEN/8):0]      vl_i,
    input  logic [2:0]                   vsew_i,
    input  logic [$clog2(VLEN/8)-1:0]    vstart_i,
    input  logic                         kill_i,
    output logic                         ex_req_o,
    output logic                         alu_instr_first_cycle_o,
    input  logic                         ex_valid_i,
    output logic [$clog2(VLEN/32)-1:0]   word_idx_o,
    output logic                         wb_we_o,
    output logic [3:0]                   wb_be_o,
    output logic                         done_o,
    output logic                         illegal_o,
    output logic [$clog2(VLEN/8)-1:0]    vstart_o
);

    localparam int NB   = VLEN / 8;
    localparam int VL_W = $clog2(NB) + 1;
    localparam int VS_W = $clog2(NB);
    localparam int WI_W = $clog2(VLEN / 32);
    localparam int BY_W = VL_W + 2;
    localparam logic [VL_W-1:0] NB_VL = VL_W'(NB);
    localparam logic [BY_W-1:0] NB_BY = BY_W'(NB);

    vec_seq_state_e    state_q, state_d;
    logic [WI_W-1:0]   word_idx_q, word_idx_d;
    logic [WI_W-1:0]   last_idx_q, last_idx_d;
    logic [1:0]        rem_q, rem_d;
    logic [1:0]        voff_q, voff_d;
    logic              first_word_q, first_word_d;
    logic              first_cyc_q, first_cyc_d;
    logic              illegal_q, illegal_d;

    logic [1:0]        sew_sh;
    logic              sew_ok;
    logic [VL_W-1:0]   vl_c;
    logic [BY_W-1:0]   bytes, words;
    logic [WI_W-1:0]   last_idx_w, start_word_w;
    logic [1:0]        voff_w;
    logic              skip_w;
    logic              accept;
    logic              is_last;
    logic [3:0]        be_w;

    // Byte count is clamped to the register size so word_idx can never run past the last word.
    always_comb begin
        sew_shift_calc: begin
            sew_sh = sew_shift(vsew_i);
            sew_ok = sew_legal(vsew_i);
        end
        vl_c  = (vl_i > NB_VL) ? NB_VL : vl_i;
        bytes = BY_W'(vl_c) << sew_sh;
        if (bytes > NB_BY) begin
            bytes = NB_BY;
        end
        words      = (bytes + BY_W'(3)) >> 2;
        last_idx_w = WI_W'(words - BY_W'(1));
    end

`ifdef VCVE2_VSTART_EN
    logic [BY_W-1:0]   vs_bytes;
    logic [1:0]        sew_q, sew_d;
    logic [VS_W-1:0]   vstart_q, vstart_d;

    always_comb begin
        vs_bytes     = BY_W'(vstart_i) << sew_sh;
        skip_w       = (vs_bytes >= bytes);
        start_word_w = vs_bytes[WI_W+1:2];
        voff_w       = vs_bytes[1:0];
    end

    assign vstart_o = vstart_q;
`else
    logic unused_vstart;
    assign unused_vstart = ^vstart_i;
    assign skip_w        = (bytes == '0);
    assign start_word_w  = '0;
    assign voff_w        = 2'b00;
    assign vstart_o      = '0;
`endif

    assign accept  = start_i && (state_q == IDLE);
    assign is_last = (word_idx_q == last_idx_q);

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        last_idx_d   = last_idx_q;
        rem_d        = rem_q;
        voff_d       = voff_q;
        first_word_d = first_word_q;
        first_cyc_d  = 1'b0;
        illegal_d    = 1'b0;
`ifdef VCVE2_VSTART_EN
        sew_d        = sew_q;
        vstart_d     = vstart_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sew_ok) begin
                        illegal_d = 1'b1;
                    end else if (skip_w) begin
                        state_d = DONE;
                    end else begin
                        state_d      = EXEC;
                        word_idx_d   = start_word_w;
                        last_idx_d   = last_idx_w;
                        rem_d        = bytes[1:0];
                        voff_d       = voff_w;
                        first_word_d = 1'b1;
                        first_cyc_d  = 1'b1;
                    end
`ifdef VCVE2_VSTART_EN
                    sew_d    = sew_sh;
                    vstart_d = '0;
`endif
                end
            end
            EXEC: begin
                if (ex_valid_i) begin
                    first_word_d = 1'b0;
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        word_idx_d  = word_idx_q + WI_W'(1);
                        first_cyc_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Kill beats every other transition, including a coincident last-word completion.
        if (kill_i) begin
            state_d     = IDLE;
            first_cyc_d = 1'b0;
            illegal_d   = 1'b0;
`ifdef VCVE2_VSTART_EN
            if (state_q == EXEC) begin
                vstart_d = VS_W'({word_idx_q, 2'b00} >> sew_q);
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            last_idx_q   <= '0;
            rem_q        <= '0;
            voff_q       <= '0;
            first_word_q <= 1'b0;
            first_cyc_q  <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef VCVE2_VSTART_EN
            sew_q        <= '0;
            vstart_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            last_idx_q   <= last_idx_d;
            rem_q        <= rem_d;
            voff_q       <= voff_d;
            first_word_q <= first_word_d;
            first_cyc_q  <= first_cyc_d;
            illegal_q    <= illegal_d;
`ifdef VCVE2_VSTART_EN
            sew_q        <= sew_d;
            vstart_q     <= vstart_d;
`endif
        end
    end

    vcve2_vec_tail_mask u_tail_mask (
        .rem_i   (rem_q),
        .voff_i  (voff_q),
        .first_i (first_word_q),
        .last_i  (is_last),
        .be_o    (be_w)
    );

    assign ready_o                 = (state_q == IDLE);
    assign ex_req_o                = (state_q == EXEC);
    assign alu_instr_first_cycle_o = (state_q == EXEC) && first_cyc_q;
    assign wb_we_o                 = (state_q == EXEC) && ex_valid_i && !kill_i;
    assign wb_be_o                 = wb_we_o ? be_w : 4'b0000;
    assign done_o                  = (state_q == DONE) && !kill_i;
    assign illegal_o               = illegal_q;
    assign word_idx_o              = word_idx_q;

endmodule

// File: tb/tb_vcve2_vec_sequencer.sv
// Directed bench for vcve2_vec_sequencer (VLEN=128); vstart expectations follow VCVE2_VSTART_EN.
module tb_vcve2_vec_sequencer;
    import vcve2_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       ready_o;
    logic [4:0] vl_i = '0;
    logic [2:0] vsew_i = '0;
    logic [3:0] vstart_i = '0;
    logic       kill_i = 1'b0;
    logic       ex_req_o;
    logic       alu_instr_first_cycle_o;
    logic       ex_valid_i = 1'b0;
    logic [1:0] word_idx_o;
    logic       wb_we_o;
    logic [3:0] wb_be_o;
    logic       done_o;
    logic       illegal_o;
    logic [3:0] vstart_o;

    int checks = 0;
    int failures = 0;

    int wr_cnt = 0, first_cnt = 0, done_cnt = 0, stall_err = 0;
    logic [3:0] be_log [64];
    logic [1:0] idx_log [64];
    logic       prev_stall = 1'b0;
    logic [1:0] prev_idx = '0;

    vcve2_vec_sequencer #(.VLEN(128)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .start_i                 (start_i),
        .ready_o                 (ready_o),
        .vl_i                    (vl_i),
        .vsew_i                  (vsew_i),
        .vstart_i                (vstart_i),
        .kill_i                  (kill_i),
        .ex_req_o                (ex_req_o),
        .alu_instr_first_cycle_o (alu_instr_first_cycle_o),
        .ex_valid_i              (ex_valid_i),
        .word_idx_o              (word_idx_o),
        .wb_we_o                 (wb_we_o),
        .wb_be_o                 (wb_be_o),
        .done_o                  (done_o),
        .illegal_o               (illegal_o),
        .vstart_o                (vstart_o)
    );

    always #5 clk_i = ~clk_i;

    // Mid-cycle observer: logs every write and tracks index stability while EX stalls.
    always @(negedge clk_i) begin
        if (wb_we_o && wr_cnt < 64) begin
            be_log[wr_cnt]  = wb_be_o;
            idx_log[wr_cnt] = word_idx_o;
            wr_cnt++;
        end
        if (alu_instr_first_cycle_o) first_cnt++;
        if (done_o) done_cnt++;
        if (ex_req_o && prev_stall && word_idx_o != prev_idx) stall_err++;
        prev_stall = ex_req_o && !ex_valid_i;
        prev_idx   = word_idx_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one instruction; EX answers on the lat-th cycle of each word.
    // done_edge = clock edges after the accept edge at which done_o is captured (-1 on timeout).
    task automatic run(input logic [4:0] vl, input logic [2:0] sew, input int lat, output int done_edge);
        int wc;
        wc = 0;
        done_edge = -1;
        start_i = 1'b1; vl_i = vl; vsew_i = sew;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done_o) begin
                done_edge = k + 1;
                break;
            end
            if (ex_req_o) begin
                wc++;
                if (wc == lat) begin
                    ex_valid_i = 1'b1;
                    wc = 0;
                end else begin
                    ex_valid_i = 1'b0;
                end
            end else begin
                ex_valid_i = 1'b0;
            end
            step();
        end
        ex_valid_i = 1'b0;
        step();
    endtask

    initial begin
        int de, base, fbase, sbase, dbase;
        logic [31:0] exp_vs;

        repeat (2) step();
        chk("rst_ready", ready_o, 1);
        chk("rst_ex_req", ex_req_o, 0);
        chk("rst_first", alu_instr_first_cycle_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_be", wb_be_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_idx", word_idx_o, 0);
        chk("rst_vstart", vstart_o, 0);
        rst_i = 1'b0;
        step();

        // vl=16 SEW8: four full words
        base = wr_cnt;
        run(5'd16, VSEW_8, 1, de);
        chk("s8_done_edge", de, 5);
        chk("s8_writes", wr_cnt - base, 4);
        for (int i = 0; i < 4; i++) chk("s8_be", be_log[base + i], 4'b1111);
        chk("s8_last_idx", idx_log[base + 3], 3);
        chk("s8_ready_after", ready_o, 1);

        // vl=5 SEW16: 10 bytes -> 3 words, tail of 2 bytes
        base = wr_cnt;
        run(5'd5, VSEW_16, 1, de);
        chk("s16_done_edge", de, 4);
        chk("s16_writes", wr_cnt - base, 3);
        chk("s16_be0", be_log[base], 4'b1111);
        chk("s16_be2", be_log[base + 2], 4'b0011);

        // vl=3 SEW8: single partial word
        base = wr_cnt;
        run(5'd3, VSEW_8, 1, de);
        chk("s8p_done_edge", de, 2);
        chk("s8p_writes", wr_cnt - base, 1);
        chk("s8p_be", be_log[base], 4'b0111);

        // vl=2 SEW32, three-cycle EX per word
        base = wr_cnt; fbase = first_cnt; sbase = stall_err;
        run(5'd2, VSEW_32, 3, de);
        chk("s32_done_edge", de, 7);
        chk("s32_writes", wr_cnt - base, 2);
        chk("s32_idx0", idx_log[base], 0);
        chk("s32_idx1", idx_log[base + 1], 1);
        chk("s32_first_cnt", first_cnt - fbase, 2);
        chk("s32_stall_hold", stall_err - sbase, 0);

        // vl beyond VLEN/8 is clamped; SEW32 with vl=16 also clamps bytes to the register size
        base = wr_cnt;
        run(5'd31, VSEW_8, 1, de);
        chk("clamp8_writes", wr_cnt - base, 4);
        chk("clamp8_last_idx", idx_log[base + 3], 3);
        base = wr_cnt;
        run(5'd16, VSEW_32, 1, de);
        chk("clamp32_done_edge", de, 5);
        chk("clamp32_writes", wr_cnt - base, 4);
        chk("clamp32_be_last", be_log[base + 3], 4'b1111);

        // vl=0: straight to DONE, single done pulse, no write
        base = wr_cnt; dbase = done_cnt;
        run(5'd0, VSEW_8, 1, de);
        chk("vl0_done_edge", de, 1);
        chk("vl0_writes", wr_cnt - base, 0);
        chk("vl0_done_pulses", done_cnt - dbase, 1);

        // illegal SEW
        base = wr_cnt;
        start_i = 1'b1; vl_i = 5'd4; vsew_i = 3'b011;
        step();
        start_i = 1'b0;
        chk("ill_pulse", illegal_o, 1);
        chk("ill_no_req", ex_req_o, 0);
        chk("ill_ready", ready_o, 1);
        step();
        chk("ill_pulse_end", illegal_o, 0);
        chk("ill_no_req2", ex_req_o, 0);
        chk("ill_writes", wr_cnt - base, 0);

        // kill coincident with ex_valid on word 1
        base = wr_cnt; dbase = done_cnt;
        start_i = 1'b1; vl_i = 5'd16; vsew_i = VSEW_8;
        step();
        start_i = 1'b0;
        ex_valid_i = 1'b1;
        step();
        chk("kill_idx", word_idx_o, 1);
        kill_i = 1'b1;
        #1;
        chk("kill_we", wb_we_o, 0);
        step();
        kill_i = 1'b0; ex_valid_i = 1'b0;
        chk("kill_ready", ready_o, 1);
        chk("kill_no_req", ex_req_o, 0);
`ifdef VCVE2_VSTART_EN
        exp_vs = 32'd4;
`else
        exp_vs = 32'd0;
`endif
        chk("kill_vstart", vstart_o, exp_vs);
        step();
        chk("kill_writes", wr_cnt - base, 1);
        chk("kill_no_done", done_cnt - dbase, 0);

        // start while busy is ignored; reset mid-EXEC aborts with no write
        base = wr_cnt;
        start_i = 1'b1; vl_i = 5'd16; vsew_i = VSEW_8;
        step();
        vsew_i = 3'b011;
        step();
        start_i = 1'b0;
        chk("busy_no_illegal", illegal_o, 0);
        chk("busy_still_exec", ex_req_o, 1);
        chk("busy_not_ready", ready_o, 0);
        rst_i = 1'b1; ex_valid_i = 1'b1;
        #1;
        chk("rstmid_ready", ready_o, 1);
        chk("rstmid_we", wb_we_o, 0);
        chk("rstmid_idx", word_idx_o, 0);
        step();
        rst_i = 1'b0; ex_valid_i = 1'b0;
        step();
        chk("rstmid_ready_after", ready_o, 1);
        chk("rstmid_writes", wr_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
